// File: rtl/aes_pkg.sv
// Shared AES-128 definitions used by encrypt_seq and decrypt.
// Contains block type, S-box, xtime, round constants, FSM state enum and
// column helpers for the row-major byte packing (element [15-(4r+c)] = row r, col c).
package aes_pkg;

   localparam int NR = 10;

   typedef logic [15:0][7:0] block_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } aes_fsm_t;

   // Forward S-box, entry 0 in the leftmost byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Out-of-range indices (idle counter value 0) yield zero.
   function automatic logic [7:0] rcon_at(input logic [3:0] i);
      logic [7:0] r;
      r = 8'h00;
      if (i >= 4'd1 && i <= 4'd10) r = RCON[i];
      return r;
   endfunction

   function automatic logic [3:0] bidx(input int r, input int c);
      return 4'(15 - (4 * r + c));
   endfunction

   // Column c as a word {row0, row1, row2, row3}.
   function automatic logic [31:0] col_of(input block_t b, input int c);
      return {b[bidx(0, c)], b[bidx(1, c)], b[bidx(2, c)], b[bidx(3, c)]};
   endfunction

   function automatic block_t from_cols(input logic [31:0] w0, input logic [31:0] w1,
                                        input logic [31:0] w2, input logic [31:0] w3);
      block_t b;
      logic [31:0] w;
      b = '0;
      for (int c = 0; c < 4; c++) begin
         case (c)
            0:       w = w0;
            1:       w = w1;
            2:       w = w2;
            default: w = w3;
         endcase
         b[bidx(0, c)] = w[31:24];
         b[bidx(1, c)] = w[23:16];
         b[bidx(2, c)] = w[15:8];
         b[bidx(3, c)] = w[7:0];
      end
      return b;
   endfunction

endpackage

// File: rtl/encrypt_round.sv
// One combinational AES-128 encryption round plus the matching key-schedule step.
// MixColumns is bypassed when last is set (final round).
module encrypt_round
   import aes_pkg::*;
(
   input  block_t     st,
   input  block_t     rk,
   input  logic [7:0] rcon,
   input  logic       last,
   output block_t     st_next,
   output block_t     rk_next
);

   block_t      sr;
   block_t      mc;
   logic [31:0] w0, w1, w2, w3;
   logic [31:0] tmp;
   logic [31:0] n0, n1, n2, n3;

   // Next round key: RotWord, SubWord and Rcon on the last column, then ripple xor.
   always_comb begin
      w0  = col_of(rk, 0);
      w1  = col_of(rk, 1);
      w2  = col_of(rk, 2);
      w3  = col_of(rk, 3);
      tmp = {sub_byte(w3[23:16]) ^ rcon, sub_byte(w3[15:8]),
             sub_byte(w3[7:0]), sub_byte(w3[31:24])};
      n0  = w0 ^ tmp;
      n1  = w1 ^ n0;
      n2  = w2 ^ n1;
      n3  = w3 ^ n2;
      rk_next = from_cols(n0, n1, n2, n3);
   end

   // SubBytes fused with ShiftRows: row r takes its bytes from column (c+r) mod 4.
   always_comb begin
      sr = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            sr[bidx(r, c)] = sub_byte(st[bidx(r, (c + r) % 4)]);
         end
      end
   end

   // MixColumns on each column of the shifted state.
   always_comb begin
      logic [7:0] a0, a1, a2, a3;
      mc = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = sr[bidx(0, c)];
         a1 = sr[bidx(1, c)];
         a2 = sr[bidx(2, c)];
         a3 = sr[bidx(3, c)];
         mc[bidx(0, c)] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mc[bidx(1, c)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mc[bidx(2, c)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mc[bidx(3, c)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
   end

   // AddRoundKey with the freshly expanded key.
   always_comb begin
      st_next = (last ? sr : mc) ^ rk_next;
   end

endmodule

// File: rtl/encrypt_seq.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Optional macro ENCRYPT_LAST_KEY_EN adds the key_last port/register (round-10 key
// for the decrypt block); without it the port and register are absent.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; outputs hold last result
// RUN   | one round per cycle, rnd = round being computed (1..10)
module encrypt_seq
   import aes_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   start,
   input  block_t state,
   input  block_t key,
   output block_t out,
`ifdef ENCRYPT_LAST_KEY_EN
   output block_t key_last,
`endif
   output logic   busy,
   output logic   done
);

   aes_fsm_t   fsm_q, fsm_d;
   block_t     st_q, st_d;
   block_t     rk_q, rk_d;
   logic [3:0] rnd_q, rnd_d;
   logic [7:0] rcon;
   block_t     out_q, out_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   block_t     st_next;
   block_t     rk_next;
   logic       last;
`ifdef ENCRYPT_LAST_KEY_EN
   block_t     kl_q, kl_d;
`endif

   assign rcon = rcon_at(rnd_q);
   assign last = (rnd_q == 4'(NR));

   encrypt_round u_round (
      .st      (st_q),
      .rk      (rk_q),
      .rcon    (rcon),
      .last    (last),
      .st_next (st_next),
      .rk_next (rk_next)
   );

   // Next-state and datapath control; done only pulses on the round-10 cycle.
   always_comb begin
      fsm_d  = fsm_q;
      st_d   = st_q;
      rk_d   = rk_q;
      rnd_d  = rnd_q;
      out_d  = out_q;
      busy_d = busy_q;
      done_d = 1'b0;
`ifdef ENCRYPT_LAST_KEY_EN
      kl_d   = kl_q;
`endif
      case (fsm_q)
         IDLE: begin
            if (start) begin
               st_d   = state ^ key;
               rk_d   = key;
               rnd_d  = 4'd1;
               busy_d = 1'b1;
               fsm_d  = RUN;
            end
         end
         RUN: begin
            st_d  = st_next;
            rk_d  = rk_next;
            rnd_d = rnd_q + 4'd1;
            if (last) begin
               out_d  = st_next;
`ifdef ENCRYPT_LAST_KEY_EN
               kl_d   = rk_next;
`endif
               done_d = 1'b1;
               busy_d = 1'b0;
               rnd_d  = 4'd0;
               fsm_d  = IDLE;
            end
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   // State register; reset wins over everything, including a pending start.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q  <= IDLE;
         st_q   <= '0;
         rk_q   <= '0;
         rnd_q  <= '0;
         out_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef ENCRYPT_LAST_KEY_EN
         kl_q   <= '0;
`endif
      end else begin
         fsm_q  <= fsm_d;
         st_q   <= st_d;
         rk_q   <= rk_d;
         rnd_q  <= rnd_d;
         out_q  <= out_d;
         busy_q <= busy_d;
         done_q <= done_d;
`ifdef ENCRYPT_LAST_KEY_EN
         kl_q   <= kl_d;
`endif
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign done = done_q;
`ifdef ENCRYPT_LAST_KEY_EN
   assign key_last = kl_q;
`endif

endmodule

// File: tb/tb_encrypt_seq.sv
// Directed bench for encrypt_seq using FIPS-197 App. B and App. C.1 vectors.
// key_last checks are compiled in only with ENCRYPT_LAST_KEY_EN.
module tb_encrypt_seq;
   import aes_pkg::*;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KL_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KL_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic   clk;
   logic   reset;
   logic   start;
   block_t pt;
   block_t ky;
   block_t ct;
   logic   busy;
   logic   done;
`ifdef ENCRYPT_LAST_KEY_EN
   block_t kl;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int ndone;

   encrypt_seq dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .state    (pt),
      .key      (ky),
      .out      (ct),
`ifdef ENCRYPT_LAST_KEY_EN
      .key_last (kl),
`endif
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIPS byte string (byte 0 leftmost) to the row-major bus packing.
   function automatic block_t to_blk(input logic [127:0] f);
      block_t b;
      b = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            b[15 - (4 * r + c)] = f[127 - 8 * (4 * c + r) -: 8];
      return b;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      pt    = '0;
      ky    = '0;
      step();
      step();
      check("reset_out", ct, '0);
      check("reset_busy", {127'b0, busy}, '0);
      check("reset_done", {127'b0, done}, '0);
`ifdef ENCRYPT_LAST_KEY_EN
      check("reset_key_last", kl, '0);
`endif
      reset = 1'b0;
      step();

      // App. B with full latency profile
      pt = to_blk(PT_B);
      ky = to_blk(KEY_B);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int j = 0; j < 10; j++) begin
         check($sformatf("b_busy_%0d", j), {127'b0, busy}, 128'd1);
         check($sformatf("b_done_%0d", j), {127'b0, done}, '0);
         step();
      end
      check("b_done", {127'b0, done}, 128'd1);
      check("b_busy_end", {127'b0, busy}, '0);
      check("b_out", ct, to_blk(CT_B));
      check("b_out15", {120'b0, ct[15]}, 128'h39);
`ifdef ENCRYPT_LAST_KEY_EN
      check("b_key_last", kl, to_blk(KL_B));
      check("b_key_last15", {120'b0, kl[15]}, 128'hd0);
`endif
      step();
      check("b_done_pulse", {127'b0, done}, '0);
      check("b_out_hold", ct, to_blk(CT_B));

      // App. C.1 single block
      pt = to_blk(PT_C);
      ky = to_blk(KEY_C);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int j = 0; j < 10; j++) step();
      check("c_done", {127'b0, done}, 128'd1);
      check("c_out", ct, to_blk(CT_C));
`ifdef ENCRYPT_LAST_KEY_EN
      check("c_key_last", kl, to_blk(KL_C));
`endif

      // Start during RUN is ignored, not queued
      pt = to_blk(PT_B);
      ky = to_blk(KEY_B);
      start = 1'b1;
      step();
      start = 1'b0;
      ndone = 0;
      for (int j = 1; j <= 10; j++) begin
         if (j == 4) begin
            pt = to_blk(PT_C);
            ky = to_blk(KEY_C);
            start = 1'b1;
         end
         step();
         start = 1'b0;
         if (done) ndone++;
      end
      check("ign_done", {127'b0, done}, 128'd1);
      check("ign_out", ct, to_blk(CT_B));
      for (int j = 0; j < 12; j++) begin
         step();
         if (done) ndone++;
      end
      check("ign_single_done", 128'(ndone), 128'd1);
      check("ign_busy", {127'b0, busy}, '0);

      // Reset mid-operation aborts
      pt = to_blk(PT_C);
      ky = to_blk(KEY_C);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int j = 1; j <= 4; j++) step();
      reset = 1'b1;
      step();
      check("rst_out", ct, '0);
      check("rst_busy", {127'b0, busy}, '0);
      check("rst_done", {127'b0, done}, '0);
      reset = 1'b0;
      ndone = 0;
      for (int j = 0; j < 12; j++) begin
         step();
         if (done) ndone++;
      end
      check("rst_no_done", 128'(ndone), '0);
      pt = to_blk(PT_B);
      ky = to_blk(KEY_B);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int j = 0; j < 10; j++) step();
      check("rst_fresh_done", {127'b0, done}, 128'd1);
      check("rst_fresh_out", ct, to_blk(CT_B));

      // Back-to-back: C.1 started on the App. B done cycle
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int j = 0; j < 10; j++) step();
      check("bb_first_done", {127'b0, done}, 128'd1);
      check("bb_first_out", ct, to_blk(CT_B));
      pt = to_blk(PT_C);
      ky = to_blk(KEY_C);
      start = 1'b1;
      step();
      start = 1'b0;
      ndone = 0;
      for (int j = 1; j <= 9; j++) begin
         if (done) ndone++;
         if (ct !== to_blk(CT_B)) ndone += 100;
         step();
      end
      if (done) ndone++;
      if (ct !== to_blk(CT_B)) ndone += 100;
      check("bb_hold_no_done", 128'(ndone), '0);
      step();
      check("bb_second_done", {127'b0, done}, 128'd1);
      check("bb_second_out", ct, to_blk(CT_C));
`ifdef ENCRYPT_LAST_KEY_EN
      check("bb_key_last", kl, to_blk(KL_C));
`endif
      step();
      check("bb_done_clear", {127'b0, done}, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
